// File: rtl/sram_mem_stage_pkg.sv
// Shared definitions for the MEM stage: access state encoding and SRAM defaults.
package sram_mem_stage_pkg;

  // Access sequencer states: each 32-bit word is two half-word phases.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } mem_state_t;

  // Byte address that maps onto SRAM word 0.
  localparam int unsigned MEM_BASE_ADDR = 1024;

  // Default external SRAM geometry (half-word addressed, 16-bit data).
  localparam int unsigned SRAM_AW_DEF = 18;
  localparam int unsigned SRAM_DW_DEF = 16;

  // True for the states that drive one half-word access on the SRAM bus.
  function automatic logic is_half_state(input mem_state_t s);
    return (s == RD_LO) || (s == RD_HI) || (s == WR_LO) || (s == WR_HI);
  endfunction

  // True for the two store phases.
  function automatic logic is_write_state(input mem_state_t s);
    return (s == WR_LO) || (s == WR_HI);
  endfunction

endpackage

// File: rtl/sram_mem_stage_phase.sv
// Phase counter for one half-word access: flags the final cycle and shapes
// the write strobe so address/data are held for one cycle after we_n rises.
module sram_mem_stage_phase #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic is_write,
  output logic last,
  output logic we_n
);

  localparam int unsigned CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES);

  logic [CW-1:0] cnt;

  assign last = active && (cnt == LAST_CNT);
  assign we_n = !(active && is_write && (cnt < LAST_CNT));

  // Count cycles within a half access; wraps to zero at every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (active && !last) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/sram_mem_stage.sv
// MEM stage: performs each 32-bit load/store as two half-word accesses on a
// 16-bit asynchronous SRAM and holds the pipeline off via ready while busy.
module sram_mem_stage
  import sram_mem_stage_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = MEM_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_AW     = SRAM_AW_DEF,
  parameter int unsigned SRAM_DW     = SRAM_DW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        val_rm,
  output logic [31:0]        mem_rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_o,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  mem_state_t state;
  mem_state_t state_nx;

  logic               ph_last;
  logic               ph_we_n;
  logic [31:0]        offset;
  logic [SRAM_AW-1:0] addr_lo;
  logic [SRAM_AW-1:0] addr_hi;
  logic [SRAM_DW-1:0] rd_lo;
  logic [SRAM_DW-1:0] rd_hi;
  logic               unused_addr_bits;

  // Word offset from the SRAM window; below-base addresses wrap unsigned.
  assign offset  = alu_res - 32'(BASE_ADDR);
  assign addr_lo = {offset[SRAM_AW:2], 1'b0};
  assign addr_hi = {offset[SRAM_AW:2], 1'b1};
  assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0], rd_hi};

  sram_mem_stage_phase #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (is_half_state(state)),
    .is_write (is_write_state(state)),
    .last     (ph_last),
    .we_n     (ph_we_n)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: stores win over loads; DONE always returns to IDLE so a
  // still-held request is not restarted before the pipeline advances.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (mem_w_en)      state_nx = WR_LO;
        else if (mem_r_en) state_nx = RD_LO;
      end
      RD_LO:   if (ph_last) state_nx = RD_HI;
      RD_HI:   if (ph_last) state_nx = DONE;
      WR_LO:   if (ph_last) state_nx = WR_HI;
      WR_HI:   if (ph_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // SRAM bus and ready decode; bus is parked whenever no half access runs.
  always_comb begin
    sram_addr  = '0;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    ready      = 1'b0;
    case (state)
      IDLE:  ready = !mem_r_en && !mem_w_en;
      DONE:  ready = 1'b1;
      RD_LO: sram_addr = addr_lo;
      RD_HI: sram_addr = addr_hi;
      WR_LO: begin
        sram_addr  = addr_lo;
        sram_dq_o  = SRAM_DW'(val_rm[15:0]);
        sram_dq_oe = 1'b1;
        sram_we_n  = ph_we_n;
      end
      WR_HI: begin
        sram_addr  = addr_hi;
        sram_dq_o  = SRAM_DW'(val_rm[31:16]);
        sram_dq_oe = 1'b1;
        sram_we_n  = ph_we_n;
      end
      default: ;
    endcase
  end

  // Capture each read half on its last cycle; the load result is published
  // together with the high half so it is valid when ready rises in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_lo     <= '0;
      rd_hi     <= '0;
      mem_rdata <= '0;
    end else if ((state == RD_LO) && ph_last) begin
      rd_lo <= sram_dq_i;
    end else if ((state == RD_HI) && ph_last) begin
      rd_hi     <= sram_dq_i;
      mem_rdata <= 32'({sram_dq_i, rd_lo});
    end
  end

endmodule

// File: tb/tb_sram_mem_stage.sv
// Bench for sram_mem_stage: SRAM model plus a word-level reference memory.
module tb_sram_mem_stage;

  localparam int unsigned WAIT = 1;
  localparam int unsigned AW   = 18;
  localparam int unsigned DW   = 16;
  localparam int          LAT  = 2 * (WAIT + 1) + 1;

  logic          clk;
  logic          rst_n;
  logic          mem_r_en;
  logic          mem_w_en;
  logic [31:0]   alu_res;
  logic [31:0]   val_rm;
  logic [31:0]   mem_rdata;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_o;
  logic [DW-1:0] sram_dq_i;
  logic          sram_dq_oe;
  logic          sram_we_n;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0]    sram [0:(1<<AW)-1];
  logic [AW+DW-1:0] wlog [$];
  logic [31:0]      ref_words [int unsigned];
  logic [31:0]      last_rd;

  sram_mem_stage #(
    .BASE_ADDR   (1024),
    .WAIT_CYCLES (WAIT),
    .SRAM_AW     (AW),
    .SRAM_DW     (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .alu_res    (alu_res),
    .val_rm     (val_rm),
    .mem_rdata  (mem_rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM: combinational read, write while we_n is low.
  assign sram_dq_i = sram[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) begin
      sram[sram_addr] <= sram_dq_o;
      wlog.push_back({sram_addr, sram_dq_o});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: SRAM word index selected by a byte address.
  function automatic int unsigned word_key(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'd1024) >> 2;
    return w % 32'h20000;
  endfunction

  function automatic logic [31:0] ref_read(input int unsigned k);
    if (ref_words.exists(k)) return ref_words[k];
    return 32'h0;
  endfunction

  // One access from request to the bubble cycle that follows DONE.
  // Entered and left #1 after a rising edge; leaves the request held.
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int c;
    int viol;
    int unsigned k;
    logic [AW-1:0] lo;
    logic [31:0] exp_rd;
    k  = word_key(a);
    lo = AW'(k * 2);
    mem_r_en = rd;
    mem_w_en = wr;
    alu_res  = a;
    val_rm   = d;
    wlog.delete();
    c = 0;
    viol = 0;
    @(negedge clk);
    check("req_ready", {63'd0, ready}, 64'd0);
    while (!ready && c < 50) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (!ready) begin
        if (wr && !sram_dq_oe) viol++;
        if (!wr && (sram_dq_oe || !sram_we_n)) viol++;
      end
    end
    check("latency", 64'(c), 64'(LAT));
    check("bus_dir", 64'(viol), 64'd0);
    if (wr) begin
      check("wr_count", 64'(wlog.size()), 64'(2 * WAIT));
      if (wlog.size() == 2 * WAIT) begin
        check("wr_lo", 64'(wlog[0]), 64'({lo, d[15:0]}));
        check("wr_hi", 64'(wlog[WAIT]), 64'({lo | AW'(1), d[31:16]}));
      end
      ref_words[k] = d;
      check("rdata_keep", 64'(mem_rdata), 64'(last_rd));
    end else begin
      exp_rd = ref_read(k);
      check("rdata", 64'(mem_rdata), 64'(exp_rd));
      check("rd_no_wr", 64'(wlog.size()), 64'd0);
      last_rd = exp_rd;
    end
    @(posedge clk);
    #1;
    check("bubble", {63'd0, ready}, 64'd0);
  endtask

  // Drop the request and confirm the stage sits idle without restarting.
  task automatic go_idle();
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    wlog.delete();
    @(negedge clk);
    check("idle_ready", {63'd0, ready}, 64'd1);
    @(posedge clk);
    #1;
    check("idle_no_wr", {63'd0, sram_we_n} | 64'(wlog.size() << 1), 64'd1);
  endtask

  // Store interrupted by reset during the high half.
  task automatic reset_mid_write(input logic [31:0] a, input logic [31:0] d);
    int unsigned k;
    k = word_key(a);
    mem_w_en = 1'b1;
    mem_r_en = 1'b0;
    alu_res  = a;
    val_rm   = d;
    wlog.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wr_hi_we", {63'd0, sram_we_n}, 64'd0);
    rst_n    = 1'b0;
    mem_w_en = 1'b0;
    #1;
    check("arst_we_n", {63'd0, sram_we_n}, 64'd1);
    check("arst_oe", {63'd0, sram_dq_oe}, 64'd0);
    check("arst_addr", 64'(sram_addr), 64'd0);
    check("arst_rdata", 64'(mem_rdata), 64'd0);
    check("arst_ready", {63'd0, ready}, 64'd1);
    #1;
    rst_n = 1'b1;
    check("partial_cnt", 64'(wlog.size()), 64'(WAIT));
    ref_words[k] = {ref_read(k) & 32'hFFFF0000} | {16'h0, d[15:0]};
    last_rd = 32'h0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
    rst_n    = 1'b0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    alu_res  = 32'h0;
    val_rm   = 32'h0;
    last_rd  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_we_n", {63'd0, sram_we_n}, 64'd1);
    check("rst_oe", {63'd0, sram_dq_oe}, 64'd0);
    check("rst_rdata", 64'(mem_rdata), 64'd0);
    check("rst_addr", 64'(sram_addr), 64'd0);

    run_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    go_idle();
    run_access(1'b1, 1'b0, 32'd1028, 32'h0);
    go_idle();
    run_access(1'b0, 1'b1, 32'd1032, 32'h12345678);
    run_access(1'b1, 1'b0, 32'd1033, 32'h0);
    run_access(1'b1, 1'b1, 32'd1024, 32'hCAFEF00D);
    go_idle();
    reset_mid_write(32'd1036, 32'hA5A55A5A);
    run_access(1'b1, 1'b0, 32'd1028, 32'h0);
    run_access(1'b1, 1'b0, 32'd1036, 32'h0);
    go_idle();

    for (int n = 0; n < 40; n++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) a = 32'($urandom_range(0, 1023));
      else a = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      run_access(op == 0 || op == 2 || op == 3, op == 1 || op == 2, a, $urandom);
      if ($urandom_range(0, 1) == 0) go_idle();
    end
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_mem_stage.md
Name: sram_mem_stage

Overview:
- MEM stage of the 5-stage ARM-subset pipeline; consumes the EXE/MEM register outputs (ALU result as address, Rm value as store data, memory read/write enables).
- Performs each 32-bit word access against the 16-bit external SRAM as two sequential half-word accesses.
- Drops `ready` while busy so the hazard/freeze logic stalls all upstream pipeline registers.
- Delivers the 32-bit load result to the MEM/WB register.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 1: extra cycles held per half-word access. Must be ≥1.
- SRAM_AW, 18: SRAM address width.
- SRAM_DW, 16: SRAM data width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_r_en  in  1  load request from EXE/MEM register.
- mem_w_en  in  1  store request from EXE/MEM register.
- alu_res  in  32  byte address; bits [1:0] ignored.
- val_rm  in  32  store data.
- mem_rdata  out  32  load result, held until the next load completes.
- ready  out  1  access complete or no access pending; 0 freezes the pipeline.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_o  out  SRAM_DW  write data.
- sram_dq_i  in  SRAM_DW  read data.
- sram_dq_oe  out  1  drive enable for the top-level tristate.
- sram_we_n  out  1  write strobe, active-low.

Behaviour:
- Word address: wa = (alu_res − BASE_ADDR) >> 2, 32-bit unsigned subtraction. Low half at {wa[SRAM_AW-2:0],0}; high half at {wa[SRAM_AW-2:0],1}. Upper bits truncated.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- Phase counter: 0..WAIT_CYCLES, clears on every state change.
- IDLE transitions:
  - mem_w_en=1 → WR_LO. Write has priority if both enables are set.
  - else mem_r_en=1 → RD_LO.
  - else stay in IDLE.
- Each LO/HI state lasts WAIT_CYCLES+1 cycles, then advances LO→HI→DONE.
- DONE lasts one cycle, then always goes to IDLE regardless of the enables, so the still-held request is not restarted.
- ready is combinational:
  - 1 in DONE.
  - 1 in IDLE when mem_r_en=0 and mem_w_en=0.
  - 0 otherwise, including the IDLE cycle in which a request first appears.
- Latency: a request seen in IDLE at cycle 0 raises ready in cycle 2·(WAIT_CYCLES+1)+1. With defaults, ready=1 in cycle 5.
- Inputs are held stable by the freeze and are sampled combinationally throughout; no input latching is required beyond what the freeze guarantees.
- Read states:
  - sram_dq_oe=0, sram_we_n=1, sram_addr = lo/hi address.
  - sram_dq_i is captured on the last cycle of RD_LO into rd_lo and of RD_HI into rd_hi.
  - mem_rdata={rd_hi,rd_lo} updates only on a read; writes leave it unchanged.
- Write states:
  - sram_addr is stable for the whole state.
  - sram_dq_o = val_rm[15:0] in WR_LO, val_rm[31:16] in WR_HI.
  - sram_dq_oe=1 for the whole state.
  - sram_we_n=0 while counter<WAIT_CYCLES, and 1 on the final cycle (address/data hold).
- In IDLE and DONE: sram_dq_oe=0, sram_we_n=1, sram_addr=0.
- Reset (any time, including mid-access):
  - state=IDLE, counter=0, rd_lo=rd_hi=0, mem_rdata=0.
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
  - ready then follows the IDLE rule.
  - An interrupted write may leave the SRAM partially written; this is acceptable.
- Back-to-back accesses: after DONE→IDLE the next instruction's request is seen in IDLE and starts immediately. This gives one IDLE bubble cycle, during which ready=0 if a request is present.
- Address below BASE_ADDR: wraps per the unsigned subtraction. Not trapped.

Decomposition:
- Shared pipeline package holds:
  - state enum.
  - BASE_ADDR and the default SRAM widths.
- Optional sub-module `sram_half_phase`: counter plus strobe generation, emitting `last` and `we_n` for one half access.
- Everything else stays flat.

Test Plan:
- Reset with mem_r_en=0 → ready=1, sram_we_n=1, sram_dq_oe=0, mem_rdata=0.
- Store alu_res=1028, val_rm=0xDEADBEEF, WAIT_CYCLES=1:
  - sram_addr=2 with dq_o=0xBEEF, then addr=3 with dq_o=0xDEAD.
  - we_n low one cycle per half.
  - ready=1 in cycle 5, then IDLE.
- Load alu_res=1028 with the SRAM model holding the previous store → mem_rdata=0xDEADBEEF when ready rises in cycle 5. No re-issue while enables stay high through DONE.
- Store then load back-to-back (freeze honored) → exactly two accesses, each 5 cycles plus one IDLE bubble; load returns the stored value.
- rst_n pulsed low during WR_HI → state=IDLE, we_n=1, oe=0 asynchronously. A later load completes normally.
- mem_r_en=mem_w_en=1 with alu_res=1024 → write sequence performed at addresses 0/1; mem_rdata unchanged.
